// File: rtl/grf_wr_arb.sv
// grf_wr_arb -- register-file write-port arbiter.
//
// Purpose: shares the single register-file write port between the pipeline
// write stage, which is never stalled, and a multiply/divide unit whose
// results arrive late. Late results wait in a DEPTH-entry FIFO. A pipeline
// write to the same register kills any older buffered result (newer write wins).
// Decode reads that hit a live buffered entry raise stall.
//
// Handshake: mdu_ack is !full and is computed combinationally from the stored
// count. A request is accepted at the rising edge where mdu_req && mdu_ack.
// A request with mdu_a3 == 0 is acknowledged but dropped.
//
// Optional feature: define GRF_ARB_BYPASS_EN to write an accepted nonzero
// request straight to the register file in the same cycle. This happens only
// when the pipeline is idle and the FIFO is empty.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   pipe_we/pipe_a3/pipe_wd  write-stage request (priority, never stalled)
//   mdu_req/mdu_a3/mdu_wd    deferred-result request; mdu_ack = accepted
//   grf_we/grf_a3/grf_wd     register-file write port (all zero when idle)
//   rd_a1/rd_a2, stall       decode read addresses and hazard stall
module grf_wr_arb #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_a3,
  input  logic [31:0] pipe_wd,
  input  logic        mdu_req,
  input  logic [4:0]  mdu_a3,
  input  logic [31:0] mdu_wd,
  output logic        mdu_ack,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  input  logic [4:0]  rd_a1,
  input  logic [4:0]  rd_a2,
  output logic        stall
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       a3_q [DEPTH];
  logic [4:0]       a3_d [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [31:0]      wd_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic pipe_active, full, empty, accept, bypass, enq, pop, head_valid;

  assign pipe_active = pipe_we && (pipe_a3 != 5'd0);
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign mdu_ack     = !full;
  assign accept      = mdu_req && !full;
`ifdef GRF_ARB_BYPASS_EN
  assign bypass = accept && (mdu_a3 != 5'd0) && !pipe_active && empty;
`else
  assign bypass = 1'b0;
`endif
  assign enq        = accept && (mdu_a3 != 5'd0) && !bypass;
  // The head leaves whenever the port is not taken by the pipeline; a
  // killed head drains silently.
  assign pop        = !pipe_active && !empty;
  assign head_valid = valid_q[rd_ptr_q];

  always_comb begin
    grf_we = 1'b0;
    grf_a3 = 5'd0;
    grf_wd = 32'd0;
    if (pipe_active) begin
      grf_we = 1'b1;
      grf_a3 = pipe_a3;
      grf_wd = pipe_wd;
    end else if (!empty && head_valid) begin
      grf_we = 1'b1;
      grf_a3 = a3_q[rd_ptr_q];
      grf_wd = wd_q[rd_ptr_q];
    end else if (bypass) begin
      grf_we = 1'b1;
      grf_a3 = mdu_a3;
      grf_wd = mdu_wd;
    end
  end

  // Slots outside the live window always hold valid=0, so scanning every
  // slot is equivalent to scanning only the stored entries.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (((rd_a1 != 5'd0) && (rd_a1 == a3_q[i])) ||
                         ((rd_a2 != 5'd0) && (rd_a2 == a3_q[i])))) begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    a3_d     = a3_q;
    wd_d     = wd_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Kill runs before enqueue so the entry accepted this cycle survives.
    if (pipe_active) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (a3_q[i] == pipe_a3) valid_d[i] = 1'b0;
      end
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (enq) begin
      valid_d[wr_ptr_q] = 1'b1;
      a3_d[wr_ptr_q]    = mdu_a3;
      wd_d[wr_ptr_q]    = mdu_wd;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    case ({enq, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (reset) begin
      valid_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      for (int i = 0; i < DEPTH; i++) begin
        a3_d[i] = 5'd0;
        wd_d[i] = 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    valid_q  <= valid_d;
    a3_q     <= a3_d;
    wd_q     <= wd_d;
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
  end
endmodule

// File: tb/tb_grf_wr_arb.sv
// Testbench for grf_wr_arb: directed scenarios plus a random run.
// All of them are checked against a queue-based reference model.
module tb_grf_wr_arb;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we, mdu_req, mdu_ack, grf_we, stall;
  logic [4:0]  pipe_a3, mdu_a3, grf_a3, rd_a1, rd_a2;
  logic [31:0] pipe_wd, mdu_wd, grf_wd;

  int vectors = 0;
  int miscompares = 0;

  grf_wr_arb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd),
    .mdu_req(mdu_req), .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_ack(mdu_ack),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .stall(stall)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic [4:0]  a3;
    logic [31:0] wd;
  } ent_t;

  ent_t        exp_q[$];
  logic        exp_we, exp_ack, exp_stall, exp_bypass;
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd;

  task automatic model_eval();
    bit pa = pipe_we && (pipe_a3 != 0);
    exp_ack    = exp_q.size() < DEPTH;
    exp_bypass = 1'b0;
`ifdef GRF_ARB_BYPASS_EN
    exp_bypass = mdu_req && exp_ack && (mdu_a3 != 0) && !pa && (exp_q.size() == 0);
`endif
    exp_stall = 1'b0;
    foreach (exp_q[i])
      if (exp_q[i].v && ((rd_a1 != 0 && rd_a1 == exp_q[i].a3) || (rd_a2 != 0 && rd_a2 == exp_q[i].a3)))
        exp_stall = 1'b1;
    exp_we = 1'b0; exp_a3 = 5'd0; exp_wd = 32'd0;
    if (pa) begin
      exp_we = 1'b1; exp_a3 = pipe_a3; exp_wd = pipe_wd;
    end else if (exp_q.size() > 0 && exp_q[0].v) begin
      exp_we = 1'b1; exp_a3 = exp_q[0].a3; exp_wd = exp_q[0].wd;
    end else if (exp_bypass) begin
      exp_we = 1'b1; exp_a3 = mdu_a3; exp_wd = mdu_wd;
    end
  endtask

  task automatic model_commit();
    bit pa = pipe_we && (pipe_a3 != 0);
    if (reset) begin
      exp_q.delete();
    end else begin
      if (pa) begin
        foreach (exp_q[i]) if (exp_q[i].a3 == pipe_a3) exp_q[i].v = 1'b0;
      end else if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
      if (mdu_req && exp_ack && (mdu_a3 != 0) && !exp_bypass)
        exp_q.push_back({1'b1, mdu_a3, mdu_wd});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd,
                       input logic mreq, input logic [4:0] ma3, input logic [31:0] mwd,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    reset = rst; pipe_we = pwe; pipe_a3 = pa3; pipe_wd = pwd;
    mdu_req = mreq; mdu_a3 = ma3; mdu_wd = mwd; rd_a1 = r1; rd_a2 = r2;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        1: drive(0, 0, 0, 0, 0, 0, 0, 4, 0);
        default: drive(0, 1, 5'd3, 32'h3333, 0, 0, 0, 0, 0);
      endcase
      vectors++;
      if ({grf_we, grf_a3, grf_wd, mdu_ack, stall} !== {exp_we, exp_a3, exp_wd, exp_ack, exp_stall}) begin
        miscompares++;
        $display("FAIL reset step %0d: got we/a3/wd/ack/stall=%0b/%0d/%h/%0b/%0b want %0b/%0d/%h/%0b/%0b",
                 s, grf_we, grf_a3, grf_wd, mdu_ack, stall, exp_we, exp_a3, exp_wd, exp_ack, exp_stall);
      end
      if (s == 1) begin
        vectors++;
        if ({grf_we, mdu_ack, stall} !== 3'b010) begin
          miscompares++;
          $display("FAIL reset_idle: got we/ack/stall=%0b/%0b/%0b want 0/1/0", grf_we, mdu_ack, stall);
        end
      end
      if (s == 2) begin
        vectors++;
        if (grf_we !== 1'b1) begin
          miscompares++;
          $display("FAIL reset_pipe_we: got %0b want 1", grf_we);
        end
      end
      tick();
    end
  endtask

  task automatic test_basic();
    for (int s = 0; s < 3; s++) begin
      if (s == 0) drive(0, 1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if ({grf_we, grf_a3, grf_wd, mdu_ack, stall} !== {exp_we, exp_a3, exp_wd, exp_ack, exp_stall}) begin
        miscompares++;
        $display("FAIL basic step %0d: got we/a3/wd/ack/stall=%0b/%0d/%h/%0b/%0b want %0b/%0d/%h/%0b/%0b",
                 s, grf_we, grf_a3, grf_wd, mdu_ack, stall, exp_we, exp_a3, exp_wd, exp_ack, exp_stall);
      end
      if (s < 2) begin
        vectors++;
        if ({grf_we, grf_a3, grf_wd} !== ((s == 0) ? {1'b1, 5'd5, 32'h11} : {1'b1, 5'd6, 32'h22})) begin
          miscompares++;
          $display("FAIL basic_write step %0d: got we/a3/wd=%0b/%0d/%h", s, grf_we, grf_a3, grf_wd);
        end
      end
      tick();
    end
  endtask

  task automatic test_full();
    for (int s = 0; s < 10; s++) begin
      if (s < 5) drive(0, 1, 5'd1, 32'(s), 1, 5'(10 + s), 32'h100 + 32'(s), 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if ({grf_we, grf_a3, grf_wd, mdu_ack, stall} !== {exp_we, exp_a3, exp_wd, exp_ack, exp_stall}) begin
        miscompares++;
        $display("FAIL full step %0d: got we/a3/wd/ack/stall=%0b/%0d/%h/%0b/%0b want %0b/%0d/%h/%0b/%0b",
                 s, grf_we, grf_a3, grf_wd, mdu_ack, stall, exp_we, exp_a3, exp_wd, exp_ack, exp_stall);
      end
      if (s == 4 || s == 9) begin
        vectors++;
        if (mdu_ack !== (s == 9)) begin
          miscompares++;
          $display("FAIL full_ack step %0d: got %0b want %0b", s, mdu_ack, s == 9);
        end
      end
      if (s >= 5 && s <= 8) begin
        vectors++;
        if ({grf_we, grf_a3, grf_wd} !== {1'b1, 5'(s + 5), 32'h100 + 32'(s - 5)}) begin
          miscompares++;
          $display("FAIL full_order step %0d: got we/a3/wd=%0b/%0d/%h want 1/%0d/%h",
                   s, grf_we, grf_a3, grf_wd, s + 5, 32'h100 + 32'(s - 5));
        end
      end
      tick();
    end
  endtask

  task automatic test_kill();
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: drive(0, 1, 5'd2, 32'h2, 1, 5'd7, 32'hAA, 0, 0);
        1: drive(0, 1, 5'd7, 32'hBB, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
      endcase
      vectors++;
      if ({grf_we, grf_a3, grf_wd, mdu_ack, stall} !== {exp_we, exp_a3, exp_wd, exp_ack, exp_stall}) begin
        miscompares++;
        $display("FAIL kill step %0d: got we/a3/wd/ack/stall=%0b/%0d/%h/%0b/%0b want %0b/%0d/%h/%0b/%0b",
                 s, grf_we, grf_a3, grf_wd, mdu_ack, stall, exp_we, exp_a3, exp_wd, exp_ack, exp_stall);
      end
      if (s >= 2) begin
        vectors++;
        if ({grf_we, stall} !== 2'b00) begin
          miscompares++;
          $display("FAIL kill_silent step %0d: got we/stall=%0b/%0b want 0/0", s, grf_we, stall);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    for (int s = 0; s < 7; s++) begin
      case (s)
        0: drive(0, 1, 5'd2, 32'h2, 1, 5'd9, 32'h99, 0, 0);
        1: drive(0, 1, 5'd2, 32'h3, 0, 0, 0, 5'd9, 0);
        2: drive(0, 1, 5'd2, 32'h4, 0, 0, 0, 0, 0);
        3: drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd9);
        4: drive(0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9);
        5: drive(0, 0, 0, 0, 1, 5'd0, 32'h55, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      vectors++;
      if ({grf_we, grf_a3, grf_wd, mdu_ack, stall} !== {exp_we, exp_a3, exp_wd, exp_ack, exp_stall}) begin
        miscompares++;
        $display("FAIL stall step %0d: got we/a3/wd/ack/stall=%0b/%0d/%h/%0b/%0b want %0b/%0d/%h/%0b/%0b",
                 s, grf_we, grf_a3, grf_wd, mdu_ack, stall, exp_we, exp_a3, exp_wd, exp_ack, exp_stall);
      end
      if (s >= 1 && s <= 4) begin
        vectors++;
        if (stall !== (s == 1 || s == 3)) begin
          miscompares++;
          $display("FAIL stall_flag step %0d: got %0b want %0b", s, stall, (s == 1 || s == 3));
        end
      end
      if (s == 6) begin
        vectors++;
        if (grf_we !== 1'b0) begin
          miscompares++;
          $display("FAIL zero_dest_write: got we=%0b want 0", grf_we);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_pending();
    for (int s = 0; s < 6; s++) begin
      if (s < 3)       drive(0, 1, 5'd2, 32'h2, 1, 5'(11 + s), 32'hC0 + 32'(s), 0, 0);
      else if (s == 3) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0, 0, 5'd12, 5'd13);
      vectors++;
      if ({grf_we, grf_a3, grf_wd, mdu_ack, stall} !== {exp_we, exp_a3, exp_wd, exp_ack, exp_stall}) begin
        miscompares++;
        $display("FAIL rst_pend step %0d: got we/a3/wd/ack/stall=%0b/%0d/%h/%0b/%0b want %0b/%0d/%h/%0b/%0b",
                 s, grf_we, grf_a3, grf_wd, mdu_ack, stall, exp_we, exp_a3, exp_wd, exp_ack, exp_stall);
      end
      if (s >= 4) begin
        vectors++;
        if ({grf_we, mdu_ack, stall} !== 3'b010) begin
          miscompares++;
          $display("FAIL rst_pend_empty step %0d: got we/ack/stall=%0b/%0b/%0b want 0/1/0", s, grf_we, mdu_ack, stall);
        end
      end
      tick();
    end
`ifdef GRF_ARB_BYPASS_EN
    drive(0, 0, 0, 0, 1, 5'd3, 32'h33, 0, 0);
    vectors++;
    if ({grf_we, grf_a3, grf_wd} !== {1'b1, 5'd3, 32'h33}) begin
      miscompares++;
      $display("FAIL bypass: got we/a3/wd=%0b/%0d/%h want 1/3/33", grf_we, grf_a3, grf_wd);
    end
    tick();
`endif
  endtask

  task automatic test_random();
    for (int s = 0; s < 600; s++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(1) == 1), 5'($urandom_range(7)), $urandom,
            ($urandom_range(9) < 6), 5'($urandom_range(7)), $urandom,
            5'($urandom_range(7)), 5'($urandom_range(7)));
      vectors++;
      if ({grf_we, grf_a3, grf_wd, mdu_ack, stall} !== {exp_we, exp_a3, exp_wd, exp_ack, exp_stall}) begin
        miscompares++;
        $display("FAIL random cycle %0d: got we/a3/wd/ack/stall=%0b/%0d/%h/%0b/%0b want %0b/%0d/%h/%0b/%0b",
                 s, grf_we, grf_a3, grf_wd, mdu_ack, stall, exp_we, exp_a3, exp_wd, exp_ack, exp_stall);
      end
      tick();
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    reset = 1'b1; pipe_we = 1'b0; pipe_a3 = '0; pipe_wd = '0;
    mdu_req = 1'b0; mdu_a3 = '0; mdu_wd = '0; rd_a1 = '0; rd_a2 = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_full();
    test_kill();
    test_stall();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
